calc_keypad_interface: RTL and testbench
========================================

Name: calc_keypad_interface

Overview:
- 4-function integer calculator front end for the board's 4x5 active-low push-switch matrix.
- Decodes key presses and holds two operands (regA, regB) plus a result sign.
- Performs + - * / and square, and drives eight 7-segment digits, four LED banks and a buzzer.
- Top-level I/O block of the calculator design.

Parameters:
- BEEP_CYCLES, 16, buzzer pulse length in clocks per accepted key.
- DEBOUNCE_CYCLES, 4, stable-low clocks required before a key is accepted (used only when DEBOUNCE_EN is defined).

Ports:
- sys_clk  in  1  single system clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-high reset (name kept from the codebase; asserted = 1).
- input_row1..input_row4  in  5 each  switch rows, 0 = pressed.
- beep  out  1  buzzer, 1 = sound.
- ledA, ledB, ledC, ledD  out  8 each  LEDs, 1 = lit.
- seg1..seg8  out  8 each  7-segment digits, active-low {dp,g,f,e,d,c,b,a}; seg1 is leftmost, seg8 is least significant.

Behaviour:
- Key map:
  - digit 0 = row4[0]; 1/2/3 = row3[0..2]; 4/5/6 = row2[0..2]; 7/8/9 = row1[0..2].
  - plus = row3[3], minus = row2[3], mul = row3[4], div = row2[4], square = row4[2].
  - ac = row1[3], ce = row1[4], equal = row4[4]. All other bits are ignored.
- Key capture:
  - All 20 bits pass through a 2-flop synchronizer.
  - A press event is a 1-to-0 transition of a synchronized bit. Holding a key gives exactly one event.
  - A 1-clock press must be caught.
  - At most one event is accepted per clock. Priority: ac > ce > equal > square > operators (+,-,*,/) > digits (lowest digit wins). Lower-priority events in the same clock are dropped.
- Registers:
  - regA, regB: 27-bit magnitudes.
  - sign: sign of regA.
  - op: 2 bits.
  - entered flag: a regB digit has been typed.
  - State machine: ENTER_A, ENTER_B, DIVIDE, RESULT, ERROR.
- Reset value of everything is 0. Reset enters ENTER_A.
- Digit d:
  - In ENTER_A or ENTER_B: current = current*10 + d, only if current < 10,000,000; otherwise ignored.
  - In RESULT: regA = d, sign = 0, go to ENTER_A.
  - In ERROR or DIVIDE: ignored.
- Operator:
  - In ENTER_A or RESULT: latch op, regB = 0, entered = 0, go to ENTER_B.
  - In ENTER_B: replace op only (no chaining).
- equal:
  - In ENTER_B: compute signed (sign,regA) op (+,regB) into regA/sign, go to RESULT.
  - In any other state: no effect.
- Division:
  - Enters DIVIDE: sequential restoring divider, 27 cycles, truncates toward zero, remainder discarded.
  - Keys other than ac are ignored while in DIVIDE.
  - Divide by 0 goes to ERROR.
- square: squares the displayed operand in place (regA in ENTER_A/RESULT, regB in ENTER_B). Result is positive.
- ce: clears the current entry (regA and sign in ENTER_A/RESULT; regB and entered in ENTER_B).
- ac: clears everything, go to ENTER_A. This is the only exit from ERROR, and it is honoured in every state.
- Overflow, checked on every arithmetic result, goes to ERROR:
  - magnitude > 99,999,999 when positive;
  - magnitude > 9,999,999 when negative.
- Display:
  - Shows regB when in ENTER_B with entered = 1; otherwise shows regA/sign.
  - Binary-to-BCD conversion, leading zeros blanked, value 0 shows "0" on seg8.
  - Minus sign goes on the digit immediately left of the most significant digit.
  - ERROR shows 'E' on seg8 with all other digits blank.
  - Codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, '-'=BF, E=86, blank=FF.
  - Outputs are registered and update one clock after a state or register change.
  - Reset: seg1..seg7 = FF, seg8 = C0.
- LEDs:
  - ledA[3:0] = one-hot pending op (+,-,*,/) while in ENTER_B; 0 otherwise.
  - ledB[0] = error, ledB[1] = sign, ledB[2] = busy (DIVIDE), other bits 0.
  - ledC = regA[7:0], ledD = regB[7:0].
- beep: high for BEEP_CYCLES after each accepted event. A new event restarts the count. Reset = 0.

Optional Feature:
- DEBOUNCE_EN defined: a key is accepted only after its synchronized level has been low for DEBOUNCE_CYCLES consecutive clocks. The event fires once per press; release re-arms the key.
- Not defined: plain synchronized falling-edge detection, as above.

Decomposition:
- Package calc_pkg: state enum, op encoding, key-index constants, 7-segment code constants, MAX_POS = 99,999,999, MAX_NEG = 9,999,999.
- Sub-module calc_seg_decoder: magnitude + sign + error flag to eight segment bytes (double-dabble plus blanking).

Test Plan:
- Reset, release all keys -> seg8 = C0, seg1..7 = FF, LEDs = 0, beep = 0.
- 7, div, 3, equal (1-clock presses) -> regA = 2, seg8 = A4, ledB = 0; ac -> display "0".
- 2,3,4,5, mul, 5,6,7,8, equal -> regA = 13,314,910; seg1..seg8 = F9,B0,B0,F9,99,90,F9,C0.
- ac, 3,1, minus, 5,0, equal -> sign = 1, regA = 19; seg6 = BF, seg7 = F9, seg8 = 90, ledB[1] = 1.
- 5, div, 0, equal -> ERROR, seg8 = 86; digits ignored; ac -> "0", ENTER_A.
- 9 pressed 9 times -> display 99,999,999 (9th digit ignored); square -> ERROR; plus and digit 4 pressed in the same clock -> only plus accepted, beep high for 16 clocks.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared types and constants for the calculator front end:
//               state and operator encodings, key-matrix bit indices,
//               7-segment codes and arithmetic limits.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam int MAG_W     = 27;   // operand magnitude width
    localparam int KEY_COUNT = 20;   // 4 rows x 5 columns
    localparam int DIGITS    = 8;    // 7-segment digits

    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_ENTER_B = 3'd1,
        ST_DIVIDE  = 3'd2,
        ST_RESULT  = 3'd3,
        ST_ERROR   = 3'd4
    } calc_state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } calc_op_e;

    typedef enum logic [2:0] {
        KEY_NONE  = 3'd0,
        KEY_DIGIT = 3'd1,
        KEY_OP    = 3'd2,
        KEY_SQ    = 3'd3,
        KEY_EQ    = 3'd4,
        KEY_CE    = 3'd5,
        KEY_AC    = 3'd6
    } key_kind_e;

    // Key bit index = (row-1)*5 + column, rows packed {row4,row3,row2,row1}
    localparam logic [4:0] KEY_AC_IDX    = 5'd3;   // row1[3]
    localparam logic [4:0] KEY_CE_IDX    = 5'd4;   // row1[4]
    localparam logic [4:0] KEY_MINUS_IDX = 5'd8;   // row2[3]
    localparam logic [4:0] KEY_DIV_IDX   = 5'd9;   // row2[4]
    localparam logic [4:0] KEY_PLUS_IDX  = 5'd13;  // row3[3]
    localparam logic [4:0] KEY_MUL_IDX   = 5'd14;  // row3[4]
    localparam logic [4:0] KEY_SQ_IDX    = 5'd17;  // row4[2]
    localparam logic [4:0] KEY_EQ_IDX    = 5'd19;  // row4[4]

    localparam logic [MAG_W-1:0] MAX_POS     = 27'd99_999_999;
    localparam logic [MAG_W-1:0] MAX_NEG     = 27'd9_999_999;
    localparam logic [MAG_W-1:0] ENTRY_LIMIT = 27'd10_000_000;

    // Active-low {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_ZERO  = 8'hC0;

    function automatic logic [7:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [4:0] key_of_digit(input int d);
        case (d)
            0:       return 5'd15;  // row4[0]
            1:       return 5'd10;  // row3[0]
            2:       return 5'd11;
            3:       return 5'd12;
            4:       return 5'd5;   // row2[0]
            5:       return 5'd6;
            6:       return 5'd7;
            7:       return 5'd0;   // row1[0]
            8:       return 5'd1;
            default: return 5'd2;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc_seg_decoder.sv
`default_nettype none
// ============================================================================
// Module      : calc_seg_decoder
// Description : Converts a binary magnitude plus sign/error flags into eight
//               active-low 7-segment bytes. Double-dabble BCD conversion,
//               leading-zero blanking, minus sign left of the top digit,
//               'E' on the rightmost digit when in error.
// Ports       : mag_i  - binary magnitude
//               neg_i  - value is negative
//               err_i  - show error pattern
//               segs_o - segs_o[8*j +: 8] is digit j, j=0 rightmost
// Revision    : 1.0 - initial release
// ============================================================================
module calc_seg_decoder
    import calc_pkg::*;
(
    input  logic [MAG_W-1:0]    mag_i,
    input  logic                neg_i,
    input  logic                err_i,
    output logic [8*DIGITS-1:0] segs_o
);

    logic [4*DIGITS-1:0] bcd;
    int                  msd;

    // Double-dabble; any ninth digit is shifted out (only transient values
    // inside the divider can be that large).
    always_comb begin
        bcd = '0;
        for (int i = MAG_W - 1; i >= 0; i--) begin
            for (int j = 0; j < DIGITS; j++) begin
                if (bcd[4*j +: 4] > 4'd4) begin
                    bcd[4*j +: 4] = bcd[4*j +: 4] + 4'd3;
                end
            end
            bcd = {bcd[4*DIGITS-2:0], mag_i[i]};
        end
    end

    always_comb begin
        msd = 0;
        for (int j = 1; j < DIGITS; j++) begin
            if (bcd[4*j +: 4] != 4'd0) begin
                msd = j;
            end
        end
    end

    always_comb begin
        segs_o = {DIGITS{SEG_BLANK}};
        for (int j = 0; j < DIGITS; j++) begin
            if (err_i) begin
                segs_o[8*j +: 8] = (j == 0) ? SEG_E : SEG_BLANK;
            end else if (j <= msd) begin
                segs_o[8*j +: 8] = seg_digit(bcd[4*j +: 4]);
            end else if (neg_i && (j == msd + 1)) begin
                segs_o[8*j +: 8] = SEG_MINUS;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/calc_keypad_interface.sv
`default_nettype none
// ============================================================================
// Module      : calc_keypad_interface
// Description : Four-function integer calculator front end for a 4x5
//               active-low key matrix. Captures key presses, holds two
//               operands, performs + - * / and square (sequential restoring
//               divider), drives eight 7-segment digits, LEDs and a buzzer.
// Ports       : sys_clk, rst_n (synchronous, active-high)
//               input_row1..4 - key rows, 0 = pressed
//               beep          - buzzer, 1 = sound
//               ledA..ledD    - status LEDs, 1 = lit
//               seg1..seg8    - active-low digits, seg1 leftmost
// Build macro : DEBOUNCE_EN - when defined, a key fires only after its
//               synchronized level has been low DEBOUNCE_CYCLES clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_keypad_interface
    import calc_pkg::*;
#(
    parameter int BEEP_CYCLES     = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic [4:0] input_row1,
    input  logic [4:0] input_row2,
    input  logic [4:0] input_row3,
    input  logic [4:0] input_row4,
    output logic       beep,
    output logic [7:0] ledA,
    output logic [7:0] ledB,
    output logic [7:0] ledC,
    output logic [7:0] ledD,
    output logic [7:0] seg1,
    output logic [7:0] seg2,
    output logic [7:0] seg3,
    output logic [7:0] seg4,
    output logic [7:0] seg5,
    output logic [7:0] seg6,
    output logic [7:0] seg7,
    output logic [7:0] seg8
);

    localparam int BEEP_W = $clog2(BEEP_CYCLES + 1);

    // ------------------------------------------------------------------
    // Key capture
    // ------------------------------------------------------------------
    logic [KEY_COUNT-1:0] w_keys_raw;
    logic [KEY_COUNT-1:0] sync1_q;
    logic [KEY_COUNT-1:0] sync2_q;
    logic [KEY_COUNT-1:0] w_ev;

    assign w_keys_raw = {input_row4, input_row3, input_row2, input_row1};

    always_ff @(posedge sys_clk) begin
        if (rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= w_keys_raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    // A key must be seen released before it can fire, so the all-zero
    // synchronizer state after reset never looks like a press.
    for (genvar k = 0; k < KEY_COUNT; k++) begin : g_debounce
        logic [DB_W-1:0] cnt_q;
        logic            armed_q;

        always_ff @(posedge sys_clk) begin
            if (rst_n) begin
                cnt_q   <= '0;
                armed_q <= 1'b0;
            end else if (sync2_q[k]) begin
                cnt_q   <= '0;
                armed_q <= 1'b1;
            end else if (armed_q) begin
                if (w_ev[k]) begin
                    armed_q <= 1'b0;
                end
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign w_ev[k] = armed_q && !sync2_q[k]
                         && (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1));
    end

    logic w_unused_bits;
    assign w_unused_bits = ^{w_ev[16], w_ev[18]};
`else
    logic [KEY_COUNT-1:0] prev_q;

    always_ff @(posedge sys_clk) begin
        if (rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= sync2_q;
        end
    end

    assign w_ev = prev_q & ~sync2_q;

    // Row4 bits 1 and 3 have no function; DEBOUNCE_CYCLES only matters in
    // the debounced build.
    logic w_unused_bits;
    assign w_unused_bits = ^{w_ev[16], w_ev[18], DEBOUNCE_CYCLES};
`endif

    // ------------------------------------------------------------------
    // Single-event priority select
    // ------------------------------------------------------------------
    key_kind_e  w_kind;
    calc_op_e   w_op;
    logic [3:0] w_digit;
    logic       w_dig_hit;

    always_comb begin
        w_digit   = 4'd0;
        w_dig_hit = 1'b0;
        // Scan downwards so the lowest pressed digit wins
        for (int d = 9; d >= 0; d--) begin
            if (w_ev[key_of_digit(d)]) begin
                w_digit   = 4'(d);
                w_dig_hit = 1'b1;
            end
        end

        w_op   = OP_ADD;
        w_kind = KEY_NONE;
        if (w_ev[KEY_AC_IDX])         w_kind = KEY_AC;
        else if (w_ev[KEY_CE_IDX])    w_kind = KEY_CE;
        else if (w_ev[KEY_EQ_IDX])    w_kind = KEY_EQ;
        else if (w_ev[KEY_SQ_IDX])    w_kind = KEY_SQ;
        else if (w_ev[KEY_PLUS_IDX])  begin w_kind = KEY_OP; w_op = OP_ADD; end
        else if (w_ev[KEY_MINUS_IDX]) begin w_kind = KEY_OP; w_op = OP_SUB; end
        else if (w_ev[KEY_MUL_IDX])   begin w_kind = KEY_OP; w_op = OP_MUL; end
        else if (w_ev[KEY_DIV_IDX])   begin w_kind = KEY_OP; w_op = OP_DIV; end
        else if (w_dig_hit)           w_kind = KEY_DIGIT;
    end

    // ------------------------------------------------------------------
    // Calculator state
    // ------------------------------------------------------------------
    calc_state_e       state_q;
    calc_op_e          op_q;
    logic [MAG_W-1:0]  regA_q;
    logic [MAG_W-1:0]  regB_q;
    logic              sign_q;
    logic              entered_q;
    logic [MAG_W-1:0]  rem_q;
    logic [4:0]        div_cnt_q;
    logic [BEEP_W-1:0] beep_cnt_q;

    // Signed (sign,regA) op (+,regB)
    logic [MAG_W:0]     w_sum;
    logic [MAG_W-1:0]   w_diff;
    logic [2*MAG_W-1:0] w_prod;
    logic [2*MAG_W-1:0] w_res_mag;
    logic               w_res_neg;
    logic               w_res_ovf;

    always_comb begin
        w_sum     = {1'b0, regA_q} + {1'b0, regB_q};
        w_diff    = (regA_q >= regB_q) ? (regA_q - regB_q) : (regB_q - regA_q);
        w_prod    = {{MAG_W{1'b0}}, regA_q} * {{MAG_W{1'b0}}, regB_q};
        w_res_mag = '0;
        w_res_neg = 1'b0;
        case (op_q)
            OP_ADD: begin
                if (!sign_q) begin
                    w_res_mag = {{(MAG_W-1){1'b0}}, w_sum};
                end else begin
                    w_res_mag = {{MAG_W{1'b0}}, w_diff};
                    w_res_neg = (regA_q > regB_q);
                end
            end
            OP_SUB: begin
                if (!sign_q) begin
                    w_res_mag = {{MAG_W{1'b0}}, w_diff};
                    w_res_neg = (regB_q > regA_q);
                end else begin
                    w_res_mag = {{(MAG_W-1){1'b0}}, w_sum};
                    w_res_neg = (w_sum != '0);
                end
            end
            OP_MUL: begin
                w_res_mag = w_prod;
                w_res_neg = sign_q && (w_prod != '0);
            end
            default: ;
        endcase
        w_res_ovf = w_res_neg ? (w_res_mag > {{MAG_W{1'b0}}, MAX_NEG})
                              : (w_res_mag > {{MAG_W{1'b0}}, MAX_POS});
    end

    // Square and digit entry act on the operand being edited
    logic [MAG_W-1:0]   w_cur;
    logic [2*MAG_W-1:0] w_sq;
    logic               w_sq_ovf;
    logic               w_cur_ok;
    logic [MAG_W-1:0]   w_cur_next;

    assign w_cur      = (state_q == ST_ENTER_B) ? regB_q : regA_q;
    assign w_sq       = {{MAG_W{1'b0}}, w_cur} * {{MAG_W{1'b0}}, w_cur};
    assign w_sq_ovf   = (w_sq > {{MAG_W{1'b0}}, MAX_POS});
    assign w_cur_ok   = (w_cur < ENTRY_LIMIT);
    assign w_cur_next = (w_cur * 27'd10) + {23'd0, w_digit};

    // Restoring divider step: regA shifts out dividend bits and collects
    // quotient bits; rem_q < regB always, so 27 bits suffice.
    logic [MAG_W:0]   w_rem_shift;
    logic             w_rem_ge;
    logic [MAG_W-1:0] w_rem_next;
    logic [MAG_W-1:0] w_quot;

    assign w_rem_shift = {rem_q, regA_q[MAG_W-1]};
    assign w_rem_ge    = (w_rem_shift >= {1'b0, regB_q});
    assign w_rem_next  = w_rem_ge ? (w_rem_shift[MAG_W-1:0] - regB_q)
                                  : w_rem_shift[MAG_W-1:0];
    assign w_quot      = {regA_q[MAG_W-2:0], w_rem_ge};

    always_ff @(posedge sys_clk) begin
        if (rst_n) begin
            state_q    <= ST_ENTER_A;
            op_q       <= OP_ADD;
            regA_q     <= '0;
            regB_q     <= '0;
            sign_q     <= 1'b0;
            entered_q  <= 1'b0;
            rem_q      <= '0;
            div_cnt_q  <= '0;
            beep_cnt_q <= '0;
        end else begin
            if (w_kind != KEY_NONE) begin
                beep_cnt_q <= BEEP_W'(BEEP_CYCLES);
            end else if (beep_cnt_q != '0) begin
                beep_cnt_q <= beep_cnt_q - 1'b1;
            end

            if (w_kind == KEY_AC) begin
                state_q   <= ST_ENTER_A;
                op_q      <= OP_ADD;
                regA_q    <= '0;
                regB_q    <= '0;
                sign_q    <= 1'b0;
                entered_q <= 1'b0;
                rem_q     <= '0;
                div_cnt_q <= '0;
            end else begin
                case (state_q)
                    ST_DIVIDE: begin
                        rem_q     <= w_rem_next;
                        regA_q    <= w_quot;
                        div_cnt_q <= div_cnt_q + 5'd1;
                        if (div_cnt_q == 5'(MAG_W - 1)) begin
                            sign_q  <= sign_q && (w_quot != '0);
                            state_q <= ((sign_q && w_quot > MAX_NEG) || w_quot > MAX_POS)
                                       ? ST_ERROR : ST_RESULT;
                        end
                    end
                    ST_ERROR: ;
                    default: begin
                        case (w_kind)
                            KEY_DIGIT: begin
                                if (state_q == ST_RESULT) begin
                                    regA_q  <= {23'd0, w_digit};
                                    sign_q  <= 1'b0;
                                    state_q <= ST_ENTER_A;
                                end else if (w_cur_ok) begin
                                    if (state_q == ST_ENTER_B) begin
                                        regB_q    <= w_cur_next;
                                        entered_q <= 1'b1;
                                    end else begin
                                        regA_q <= w_cur_next;
                                    end
                                end
                            end
                            KEY_OP: begin
                                op_q <= w_op;
                                if (state_q != ST_ENTER_B) begin
                                    regB_q    <= '0;
                                    entered_q <= 1'b0;
                                    state_q   <= ST_ENTER_B;
                                end
                            end
                            KEY_EQ: begin
                                if (state_q == ST_ENTER_B) begin
                                    if (op_q == OP_DIV) begin
                                        rem_q     <= '0;
                                        div_cnt_q <= '0;
                                        state_q   <= (regB_q == '0) ? ST_ERROR : ST_DIVIDE;
                                    end else if (w_res_ovf) begin
                                        state_q <= ST_ERROR;
                                    end else begin
                                        regA_q  <= w_res_mag[MAG_W-1:0];
                                        sign_q  <= w_res_neg;
                                        state_q <= ST_RESULT;
                                    end
                                end
                            end
                            KEY_SQ: begin
                                if (w_sq_ovf) begin
                                    state_q <= ST_ERROR;
                                end else if (state_q == ST_ENTER_B) begin
                                    regB_q <= w_sq[MAG_W-1:0];
                                end else begin
                                    regA_q <= w_sq[MAG_W-1:0];
                                    sign_q <= 1'b0;
                                end
                            end
                            KEY_CE: begin
                                if (state_q == ST_ENTER_B) begin
                                    regB_q    <= '0;
                                    entered_q <= 1'b0;
                                end else begin
                                    regA_q <= '0;
                                    sign_q <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                endcase
            end
        end
    end

    assign beep = (beep_cnt_q != '0);

    // ------------------------------------------------------------------
    // Display and LEDs (registered)
    // ------------------------------------------------------------------
    logic                w_show_b;
    logic [MAG_W-1:0]    w_disp_mag;
    logic                w_disp_neg;
    logic                w_err;
    logic [8*DIGITS-1:0] w_segs;
    logic [3:0]          w_op_onehot;

    assign w_show_b   = (state_q == ST_ENTER_B) && entered_q;
    assign w_disp_mag = w_show_b ? regB_q : regA_q;
    assign w_disp_neg = !w_show_b && sign_q;
    assign w_err      = (state_q == ST_ERROR);

    calc_seg_decoder u_seg_decoder (
        .mag_i  (w_disp_mag),
        .neg_i  (w_disp_neg),
        .err_i  (w_err),
        .segs_o (w_segs)
    );

    always_comb begin
        w_op_onehot = 4'b0000;
        if (state_q == ST_ENTER_B) begin
            case (op_q)
                OP_ADD:  w_op_onehot = 4'b0001;
                OP_SUB:  w_op_onehot = 4'b0010;
                OP_MUL:  w_op_onehot = 4'b0100;
                default: w_op_onehot = 4'b1000;
            endcase
        end
    end

    logic [8*DIGITS-1:0] seg_q;
    logic [7:0]          led_a_q;
    logic [7:0]          led_b_q;
    logic [7:0]          led_c_q;
    logic [7:0]          led_d_q;

    always_ff @(posedge sys_clk) begin
        if (rst_n) begin
            seg_q   <= {{(DIGITS-1){SEG_BLANK}}, SEG_ZERO};
            led_a_q <= '0;
            led_b_q <= '0;
            led_c_q <= '0;
            led_d_q <= '0;
        end else begin
            seg_q   <= w_segs;
            led_a_q <= {4'b0000, w_op_onehot};
            led_b_q <= {5'b00000, (state_q == ST_DIVIDE), sign_q, w_err};
            led_c_q <= regA_q[7:0];
            led_d_q <= regB_q[7:0];
        end
    end

    assign {seg1, seg2, seg3, seg4, seg5, seg6, seg7, seg8} = seg_q;
    assign ledA = led_a_q;
    assign ledB = led_b_q;
    assign ledC = led_c_q;
    assign ledD = led_d_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_keypad_interface.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_keypad_interface
// Description : Directed self-checking bench for calc_keypad_interface.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_keypad_interface;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic [19:0] keys_down;
    logic [4:0]  input_row1, input_row2, input_row3, input_row4;
    logic        beep;
    logic [7:0]  ledA, ledB, ledC, ledD;
    logic [7:0]  seg1, seg2, seg3, seg4, seg5, seg6, seg7, seg8;
    logic [63:0] segs_all;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 sys_clk = ~sys_clk;

    assign {input_row4, input_row3, input_row2, input_row1} = ~keys_down;
    assign segs_all = {seg1, seg2, seg3, seg4, seg5, seg6, seg7, seg8};

    calc_keypad_interface #(
        .BEEP_CYCLES     (16),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .input_row1 (input_row1),
        .input_row2 (input_row2),
        .input_row3 (input_row3),
        .input_row4 (input_row4),
        .beep       (beep),
        .ledA       (ledA),
        .ledB       (ledB),
        .ledC       (ledC),
        .ledD       (ledD),
        .seg1       (seg1),
        .seg2       (seg2),
        .seg3       (seg3),
        .seg4       (seg4),
        .seg5       (seg5),
        .seg6       (seg6),
        .seg7       (seg7),
        .seg8       (seg8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] key(input int row, input int col);
        logic [19:0] m;
        m = '0;
        m[(row - 1) * 5 + col] = 1'b1;
        return m;
    endfunction

    function automatic logic [19:0] dig(input int d);
        if (d == 0)      return key(4, 0);
        else if (d <= 3) return key(3, d - 1);
        else if (d <= 6) return key(2, d - 4);
        else             return key(1, d - 7);
    endfunction

    function automatic logic [19:0] k_plus();  return key(3, 3); endfunction
    function automatic logic [19:0] k_minus(); return key(2, 3); endfunction
    function automatic logic [19:0] k_mul();   return key(3, 4); endfunction
    function automatic logic [19:0] k_div();   return key(2, 4); endfunction
    function automatic logic [19:0] k_sq();    return key(4, 2); endfunction
    function automatic logic [19:0] k_ac();    return key(1, 3); endfunction
    function automatic logic [19:0] k_eq();    return key(4, 4); endfunction

    // One-clock press, then let the pipeline and display settle
    task automatic press(input logic [19:0] m);
        @(negedge sys_clk);
        keys_down = m;
        @(negedge sys_clk);
        keys_down = '0;
        repeat (8) @(negedge sys_clk);
    endtask

    localparam logic [63:0] DISP_ZERO = 64'hFFFF_FFFF_FFFF_FFC0;
    localparam logic [63:0] DISP_ERR  = 64'hFFFF_FFFF_FFFF_FF86;

    int beep_len;

    initial begin
        keys_down = '0;
        rst_n     = 1'b1;
        repeat (4) @(negedge sys_clk);
        rst_n = 1'b0;
        repeat (5) @(negedge sys_clk);

        // Reset state
        check("reset_segs", segs_all, DISP_ZERO);
        check("reset_ledA", {56'd0, ledA}, 64'h00);
        check("reset_ledB", {56'd0, ledB}, 64'h00);
        check("reset_ledC", {56'd0, ledC}, 64'h00);
        check("reset_ledD", {56'd0, ledD}, 64'h00);
        check("reset_beep", {63'd0, beep}, 64'd0);

        // 7 / 3 = 2
        press(dig(7));
        check("div7_segs", segs_all, 64'hFFFF_FFFF_FFFF_FFF8);
        press(k_div());
        check("div_ledA", {56'd0, ledA}, 64'h08);
        press(dig(3));
        check("div_regB_disp", segs_all, 64'hFFFF_FFFF_FFFF_FFB0);
        press(k_eq());
        check("div_busy", {56'd0, ledB}, 64'h04);
        repeat (40) @(negedge sys_clk);
        check("div_result", segs_all, 64'hFFFF_FFFF_FFFF_FFA4);
        check("div_ledB", {56'd0, ledB}, 64'h00);
        check("div_ledC", {56'd0, ledC}, 64'h02);
        press(k_ac());
        check("ac_zero", segs_all, DISP_ZERO);

        // 2345 * 5678 = 13,314,910
        press(dig(2)); press(dig(3)); press(dig(4)); press(dig(5));
        press(k_mul());
        press(dig(5)); press(dig(6)); press(dig(7)); press(dig(8));
        check("mul_regB_disp", segs_all, 64'hFFFF_FFFF_9282_F880);
        check("mul_ledA", {56'd0, ledA}, 64'h04);
        check("mul_ledD", {56'd0, ledD}, 64'h2E);
        press(k_eq());
        check("mul_result", segs_all, 64'hF9B0_B0F9_9990_F9C0);
        check("mul_ledC", {56'd0, ledC}, 64'h5E);

        // 31 - 50 = -19
        press(k_ac());
        press(dig(3)); press(dig(1));
        press(k_minus());
        press(dig(5)); press(dig(0));
        press(k_eq());
        check("neg_segs", segs_all, 64'hFFFF_FFFF_FFBF_F990);
        check("neg_ledB", {56'd0, ledB}, 64'h02);
        check("neg_ledC", {56'd0, ledC}, 64'h13);

        // 5 / 0 -> error; digits ignored; ac recovers
        press(dig(5));
        press(k_div());
        press(dig(0));
        press(k_eq());
        check("div0_segs", segs_all, DISP_ERR);
        check("div0_ledB", {56'd0, ledB}, 64'h01);
        press(dig(3));
        check("err_digit_ignored", segs_all, DISP_ERR);
        press(k_ac());
        check("err_ac_segs", segs_all, DISP_ZERO);
        check("err_ac_ledB", {56'd0, ledB}, 64'h00);

        // Entry limit: ninth digit ignored
        for (int i = 0; i < 9; i++) press(dig(9));
        check("max_entry", segs_all, 64'h9090_9090_9090_9090);
        check("max_ledC", {56'd0, ledC}, 64'hFF);
        press(k_sq());
        check("sq_overflow", segs_all, DISP_ERR);
        press(k_ac());
        repeat (20) @(negedge sys_clk);

        // plus and 4 in the same clock: only plus is taken
        @(negedge sys_clk);
        keys_down = k_plus() | dig(4);
        @(negedge sys_clk);
        keys_down = '0;
        beep_len = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            if (beep) beep_len++;
        end
        check("prio_ledA", {56'd0, ledA}, 64'h01);
        check("prio_segs", segs_all, DISP_ZERO);
        check("prio_ledC", {56'd0, ledC}, 64'h00);
        check("prio_ledD", {56'd0, ledD}, 64'h00);
        check("beep_len", 64'(beep_len), 64'd16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
